// File: rtl/part4_pkg.sv
// Shared types and sizes for the part-4 matrix-vector controller.
// Row/column widths are tied to the fixed 8x8 datapath.
package part4_pkg;

  localparam int DIM       = 8;
  localparam int XW_WIDTH  = 14;
  localparam int ACC_WIDTH = 28;
  localparam int ROW_W     = 3;
  localparam int COL_W     = 3;
  localparam int K_W       = ROW_W + COL_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_X,
    S_LOAD_W,
    S_COMPUTE,
    S_FINISH
  } ctrl_state_t;

endpackage

// File: rtl/controller_part4.sv
// Load/issue sequencer for the part-4 datapath: routes the word stream
// into X/W memory, issues 8 rows through the 3-stage pipe, hands off results.
module controller_part4 #(
  parameter int DIM = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       load_w,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_row,
  output logic       busy,
  output logic       done,
  output logic [2:0] addr_x,
  output logic       wr_en_x,
  output logic [5:0] addr_w,
  output logic       wr_en_w,
  output logic       clear_acc,
  output logic       en_acc,
  output logic       en_pipe
);

  import part4_pkg::*;

  localparam logic [K_W-1:0]   LAST_X   = K_W'(DIM - 1);
  localparam logic [K_W-1:0]   LAST_W   = K_W'(DIM * DIM - 1);
  localparam logic [ROW_W:0]   N_ROWS   = (ROW_W + 1)'(DIM);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(DIM - 1);

  ctrl_state_t r_state;
  ctrl_state_t w_next;

  logic [K_W-1:0]   r_k;
  logic [ROW_W:0]   r_issue;
  logic [ROW_W-1:0] r_out_row;
  logic             r_v1;
  logic             r_v2;
  logic             r_out_valid;
  logic             r_w_loaded;
  logic             r_do_w;

  logic w_in_hs;
  logic w_out_hs;
  logic w_advance;
  logic w_issue;
  logic w_k_last;
  logic w_begin;

  assign w_in_hs  = in_valid && in_ready;
  assign w_out_hs = r_out_valid && out_ready;
  assign w_begin  = (r_state == S_IDLE) && start;
  assign w_k_last = (r_state == S_LOAD_X) ? (r_k == LAST_X)
                                          : (r_k == LAST_W);

  assign busy      = (r_state != S_IDLE);
  assign out_valid = r_out_valid;
  assign out_row   = r_out_row;

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    addr_x    = '0;
    wr_en_x   = 1'b0;
    addr_w    = '0;
    wr_en_w   = 1'b0;
    clear_acc = 1'b0;
    en_acc    = 1'b0;
    en_pipe   = 1'b0;
    done      = 1'b0;
    w_advance = 1'b0;
    w_issue   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next    = S_LOAD_X;
          clear_acc = 1'b1;
        end
      end
      S_LOAD_X: begin
        in_ready = 1'b1;
        addr_x   = r_k[COL_W-1:0];
        wr_en_x  = in_valid;
        if (in_valid && w_k_last)
          w_next = r_do_w ? S_LOAD_W : S_COMPUTE;
      end
      S_LOAD_W: begin
        in_ready = 1'b1;
        addr_w   = r_k;
        wr_en_w  = in_valid;
        if (in_valid && w_k_last)
          w_next = S_COMPUTE;
      end
      S_COMPUTE: begin
        // a held result freezes the whole pipe
        w_advance = !(r_out_valid && !out_ready);
        en_pipe   = w_advance;
        w_issue   = w_advance && (r_issue < N_ROWS);
        if (w_issue)
          addr_w = {r_issue[ROW_W-1:0], COL_W'(0)};
        en_acc = w_advance && r_v2;
        if (w_out_hs && (r_out_row == LAST_ROW))
          w_next = S_FINISH;
      end
      S_FINISH: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_issue     <= '0;
      r_out_row   <= '0;
      r_v1        <= 1'b0;
      r_v2        <= 1'b0;
      r_out_valid <= 1'b0;
      r_w_loaded  <= 1'b0;
      r_do_w      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_begin) begin
        r_do_w      <= load_w || !r_w_loaded;
        r_k         <= '0;
        r_issue     <= '0;
        r_out_row   <= '0;
        r_v1        <= 1'b0;
        r_v2        <= 1'b0;
        r_out_valid <= 1'b0;
      end
      if (w_in_hs)
        r_k <= w_k_last ? '0 : r_k + 1'b1;
      if (w_in_hs && (r_state == S_LOAD_W) && w_k_last)
        r_w_loaded <= 1'b1;
      if (w_issue)
        r_issue <= r_issue + 1'b1;
      if (w_advance) begin
        r_v1 <= w_issue;
        r_v2 <= r_v1;
      end
      if (en_acc)
        r_out_valid <= 1'b1;
      else if (w_out_hs)
        r_out_valid <= 1'b0;
      if (w_out_hs)
        r_out_row <= r_out_row + 1'b1;
    end
  end

endmodule

// File: tb/tb_controller_part4.sv
// Directed bench for controller_part4 with a behavioural datapath
// (X/W memories, 2-stage dot product, saturating accumulator).
module tb_controller_part4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       load_w;
  logic       in_valid;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_row;
  logic       busy;
  logic       done;
  logic [2:0] addr_x;
  logic       wr_en_x;
  logic [5:0] addr_w;
  logic       wr_en_w;
  logic       clear_acc;
  logic       en_acc;
  logic       en_pipe;

  logic signed [13:0] in_data;
  logic signed [13:0] stream [72];
  logic signed [13:0] xm [8];
  logic signed [13:0] wm [64];
  longint             p1, p2;
  logic [27:0]        m_acc;

  logic [27:0] res_val [8];
  logic [2:0]  res_row [8];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  controller_part4 #(.DIM(8)) dut (
    .clk(clk), .rst(rst), .start(start), .load_w(load_w),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .busy(busy), .done(done),
    .addr_x(addr_x), .wr_en_x(wr_en_x),
    .addr_w(addr_w), .wr_en_w(wr_en_w),
    .clear_acc(clear_acc), .en_acc(en_acc), .en_pipe(en_pipe)
  );

  function automatic longint dot(input logic [2:0] r);
    longint s = 0;
    for (int j = 0; j < 8; j++)
      s += longint'(wm[int'(r) * 8 + j]) * longint'(xm[j]);
    return s;
  endfunction

  function automatic logic [27:0] sat28(input longint s);
    if (s > 64'sd134217727) return 28'h7FFFFFF;
    if (s < -64'sd134217728) return 28'h8000000;
    return 28'(s);
  endfunction

  always @(posedge clk) begin
    if (wr_en_x) xm[addr_x] <= in_data;
    if (wr_en_w) wm[addr_w] <= in_data;
    if (en_pipe) begin
      p1 <= dot(addr_w[5:3]);
      p2 <= p1;
    end
    if (clear_acc) m_acc <= '0;
    else if (en_acc) m_acc <= sat28(p2);
  end

  task automatic load_stream(input int xsel, input int wsel);
    for (int i = 0; i < 8; i++)
      case (xsel)
        0: stream[i] = 14'(i + 1);
        1: stream[i] = 14'(8 - i);
        default: stream[i] = 14'sd8191;
      endcase
    for (int k = 0; k < 64; k++)
      case (wsel)
        0: stream[8 + k] = (k / 8 == k % 8) ? 14'sd2 : 14'sd0;
        1: stream[8 + k] = (k / 8 == k % 8) ? 14'sd3 : 14'sd1;
        default: stream[8 + k] = 14'sd8191;
      endcase
  endtask

  task automatic do_start(input logic lw);
    @(posedge clk); #1;
    start = 1'b1;
    load_w = lw;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input int limit, input bit gaps,
                      output int nacc, output int ncyc);
    nacc = 0;
    ncyc = 0;
    while (nacc < limit && ncyc < 400) begin
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data = stream[nacc < 72 ? nacc : 0];
      #1;
      if (!in_ready) break;
      if (in_valid) nacc++;
      @(posedge clk); #1;
      ncyc++;
    end
    in_valid = 1'b0;
  endtask

  task automatic collect(input int bp_row, input int bp_len,
                         output int nout, output int first_c,
                         output int done_c, output int hold_bad);
    int bpn = 0;
    bit stalled = 0;
    logic [27:0] pv = '0;
    logic [2:0] pr = '0;
    nout = 0;
    first_c = -1;
    done_c = -1;
    hold_bad = 0;
    for (int c = 0; c < 200; c++) begin
      out_ready = !(out_valid && int'(out_row) == bp_row && bpn < bp_len);
      #1;
      if (stalled && (m_acc !== pv || out_row !== pr)) hold_bad++;
      if (out_valid && !out_ready) begin
        bpn++;
        stalled = 1;
        pv = m_acc;
        pr = out_row;
        if (en_pipe || en_acc) hold_bad++;
      end else begin
        stalled = 0;
      end
      if (out_valid && out_ready) begin
        if (first_c < 0) first_c = c;
        if (nout < 8) begin
          res_val[nout] = m_acc;
          res_row[nout] = out_row;
        end
        nout++;
      end
      if (done) begin
        done_c = c;
        break;
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if ({busy, in_ready, out_valid, done} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_flags got %b want 0000",
               {busy, in_ready, out_valid, done});
    end
    checks++;
    if (out_row !== 3'd0) begin
      errors++;
      $display("FAIL rst_row got %0d want 0", out_row);
    end
    checks++;
    if ({wr_en_x, wr_en_w, en_pipe, en_acc, clear_acc, addr_x, addr_w}
        !== 14'd0) begin
      errors++;
      $display("FAIL rst_ctrl got %b want 0",
               {wr_en_x, wr_en_w, en_pipe, en_acc, clear_acc, addr_x, addr_w});
    end
  endtask

  task automatic test_identity;
    int na, nc, no, fc, dc, hb;
    load_stream(0, 0);
    @(posedge clk); #1;
    start = 1'b1;
    load_w = 1'b1;
    #1;
    checks++;
    if (clear_acc !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL id_clear got clr=%b busy=%b want 1 0", clear_acc, busy);
    end
    @(posedge clk); #1;
    start = 1'b0;
    feed(100, 0, na, nc);
    checks++;
    if (na !== 72 || nc !== 72) begin
      errors++;
      $display("FAIL id_load got words=%0d cycles=%0d want 72 72", na, nc);
    end
    collect(-1, 0, no, fc, dc, hb);
    checks++;
    if (no !== 8 || fc !== 3 || dc !== 11) begin
      errors++;
      $display("FAIL id_timing got n=%0d first=C%0d done=C%0d want 8 C3 C11",
               no, fc, dc);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (res_val[i] !== 28'(2 * (i + 1)) || res_row[i] !== 3'(i)) begin
        errors++;
        $display("FAIL id_out[%0d] got val=%0d row=%0d want %0d %0d",
                 i, res_val[i], res_row[i], 2 * (i + 1), i);
      end
    end
  endtask

  task automatic test_reuse_w;
    int na, nc, no, fc, dc, hb;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL start_in_done got busy=%b want 0", busy);
    end
    load_stream(1, 0);
    do_start(1'b0);
    feed(100, 0, na, nc);
    checks++;
    if (na !== 8 || nc !== 8) begin
      errors++;
      $display("FAIL reuse_load got words=%0d cycles=%0d want 8 8", na, nc);
    end
    collect(-1, 0, no, fc, dc, hb);
    checks++;
    if (no !== 8 || dc !== 11) begin
      errors++;
      $display("FAIL reuse_timing got n=%0d done=C%0d want 8 C11", no, dc);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (res_val[i] !== 28'(2 * (8 - i))) begin
        errors++;
        $display("FAIL reuse_out[%0d] got %0d want %0d",
                 i, res_val[i], 2 * (8 - i));
      end
    end
  endtask

  task automatic test_forced_load;
    int na, nc, no, fc, dc, hb;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    load_stream(0, 0);
    do_start(1'b0);
    feed(100, 0, na, nc);
    checks++;
    if (na !== 72) begin
      errors++;
      $display("FAIL forced_load got words=%0d want 72", na);
    end
    collect(-1, 0, no, fc, dc, hb);
    checks++;
    if (res_val[0] !== 28'd2 || res_val[7] !== 28'd16 || dc !== 11) begin
      errors++;
      $display("FAIL forced_out got r0=%0d r7=%0d done=C%0d want 2 16 C11",
               res_val[0], res_val[7], dc);
    end
  endtask

  task automatic test_backpressure;
    int na, nc, no, fc, dc, hb;
    load_stream(0, 1);
    do_start(1'b1);
    feed(100, 1, na, nc);
    checks++;
    if (na !== 72) begin
      errors++;
      $display("FAIL bp_load got words=%0d want 72", na);
    end
    collect(3, 5, no, fc, dc, hb);
    checks++;
    if (no !== 8 || fc !== 3 || dc !== 16) begin
      errors++;
      $display("FAIL bp_timing got n=%0d first=C%0d done=C%0d want 8 C3 C16",
               no, fc, dc);
    end
    checks++;
    if (hb !== 0) begin
      errors++;
      $display("FAIL bp_hold got %0d unstable cycles want 0", hb);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (res_val[i] !== 28'(38 + 2 * i) || res_row[i] !== 3'(i)) begin
        errors++;
        $display("FAIL bp_out[%0d] got val=%0d row=%0d want %0d %0d",
                 i, res_val[i], res_row[i], 38 + 2 * i, i);
      end
    end
  endtask

  task automatic test_saturation;
    int na, nc, no, fc, dc, hb;
    load_stream(2, 2);
    do_start(1'b1);
    feed(100, 0, na, nc);
    collect(-1, 0, no, fc, dc, hb);
    checks++;
    if (na !== 72 || no !== 8) begin
      errors++;
      $display("FAIL sat_count got words=%0d outs=%0d want 72 8", na, no);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (res_val[i] !== 28'd134217727) begin
        errors++;
        $display("FAIL sat_out[%0d] got %0d want 134217727", i, res_val[i]);
      end
    end
  endtask

  task automatic test_reset_mid_job;
    int na, nc, no, fc, dc, hb;
    load_stream(0, 0);
    do_start(1'b1);
    feed(38, 0, na, nc);
    checks++;
    if (na !== 38 || in_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre got words=%0d rdy=%b busy=%b want 38 1 1",
               na, in_ready, busy);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if ({busy, in_ready, out_valid, wr_en_w} !== 4'b0000) begin
      errors++;
      $display("FAIL mid_idle got %b want 0000",
               {busy, in_ready, out_valid, wr_en_w});
    end
    do_start(1'b0);
    feed(100, 0, na, nc);
    checks++;
    if (na !== 72) begin
      errors++;
      $display("FAIL mid_reload got words=%0d want 72", na);
    end
    collect(-1, 0, no, fc, dc, hb);
    checks++;
    if (res_val[3] !== 28'd8 || dc !== 11) begin
      errors++;
      $display("FAIL mid_out got r3=%0d done=C%0d want 8 C11", res_val[3], dc);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    load_w = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    test_reset();
    test_identity();
    test_reuse_w();
    test_forced_load();
    test_backpressure();
    test_saturation();
    test_reset_mid_job();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule

// File: doc/controller_part4.md
# controller_part4

Sequencing controller that sits directly upstream of the part-4 matrix-vector datapath and drives all of its control inputs. It accepts a valid/ready word stream and routes each word into the datapath's X vector memory or W matrix memory. It then issues the 8 row dot-products through the datapath's 3-stage pipeline and presents each 28-bit result with a valid/ready handshake. `input_data` goes straight from the upstream source to the datapath; this block only generates addresses, write enables and pipeline enables.

## Interface
- `DIM`, default 8: vector length and matrix order. Only 8 is supported, because the datapath is fixed at 8.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: begin a job; sampled in IDLE only.
- `load_w` input 1: sampled with `start`. 1 = load X then W; 0 = load X only and reuse the stored W.
- `in_valid` input 1: upstream word valid (data on datapath `input_data`).
- `in_ready` output 1: word accepted when `in_valid && in_ready`.
- `out_valid` output 1: datapath `output_data` holds a row result.
- `out_ready` input 1: downstream accepts the result.
- `out_row` output 3: row index of the presented result.
- `busy` output 1: job in progress.
- `done` output 1: one-cycle pulse at job end.
- `addr_x` output 3, `wr_en_x` output 1: X memory write port.
- `addr_w` output 6, `wr_en_w` output 1: W write address/enable; `addr_w[5:3]` is also the W read row.
- `clear_acc`, `en_acc`, `en_pipe` output 1 each: datapath pipeline and accumulator controls.

## Operation
- States: IDLE, LOAD_X, LOAD_W, COMPUTE, FINISH.
- **IDLE**
  - `in_ready`=0.
  - On `start`, go to LOAD_X and assert `clear_acc` for that one cycle.
  - Latch `do_w = load_w || !w_loaded`. `w_loaded` is cleared by reset and set when LOAD_W completes.
  - `start` outside IDLE is ignored.
- **LOAD_X**
  - `in_ready`=1, `addr_x`=word counter k (0..7), `wr_en_x = in_valid`.
  - k advances only on a handshake.
  - After word 7 is accepted, go to LOAD_W if `do_w`, else COMPUTE.
- **LOAD_W**
  - `in_ready`=1, `addr_w`=k (0..63, row-major: word k goes to W[k>>3][k&7]), `wr_en_w = in_valid`.
  - After word 63 is accepted, set `w_loaded` and go to COMPUTE.
- **COMPUTE**
  - `in_ready`=0; `advance = !(out_valid && !out_ready)`.
  - `en_pipe = advance`.
  - Issue: while the issue counter r < 8 and `advance`, drive `addr_w = {r,3'b000}` and increment r.
  - Track valid bits v1 (mult reg) and v2 (adder reg); each shifts only on `advance`.
  - `en_acc = advance && v2`.
  - `out_valid` is set by `en_acc` and cleared by a handshake with no new `en_acc`.
  - `out_row` increments on each output handshake.
  - After row 7 is handed off, go to FINISH.
- **FINISH**: `done`=1 for one cycle, then IDLE.
- `busy`=1 in all states except IDLE.
- Outside their active states, all write enables, `en_pipe`, `en_acc` and `clear_acc` are 0, and the addresses are 0.
- **Reset** (including mid-job): state IDLE, all counters, `w_loaded`, v1, v2, `out_valid`, `busy`, `done` and `out_row` go to 0. Partially written datapath memories are not cleared; the next job that loads W rewrites them.

## Timing
- Load phase: one word per cycle when `in_valid` is held high. `in_valid` low only stalls the load.
- Compute latency, with C0 the first COMPUTE cycle:
  - Row r is issued in cycle Cr.
  - Its result is captured into the accumulator at the end of C(r+2).
  - `out_valid` is high for row r in C(r+3).
- With `out_ready` held at 1:
  - Rows 0–7 are presented in C3–C10.
  - `done` is asserted in C11.
  - A job with W is 8+64+12 cycles from the cycle after `start`.
- Backpressure: while `out_valid && !out_ready`, everything freezes: `en_pipe`=0, `en_acc`=0, no issue, and `out_row` and the accumulator hold. It resumes the cycle after `out_ready`.
- A handshake and a new `en_acc` in the same cycle keep `out_valid`=1 with the next row.
- `done` and `start` never overlap: `start` in the `done` cycle is ignored.

## Structure
- Shared package `part4_pkg`:
  - state enum `ctrl_state_t`
  - `DIM`=8, `XW_WIDTH`=14, `ACC_WIDTH`=28
  - row/column index widths
- Single flat module; no sub-module is required.
- Top level `matmul_part4` instantiates this block with `datapath_part4`.

## Test plan
1. Identity scaling: reset; `start`, `load_w`=1; X=1..8; W=2·I → outputs 2,4,6,…,16 with `out_row` 0..7, first `out_valid` at C3, `done` at C11.
2. Reuse W: second job with `load_w`=0 and X=8..1 → only 8 words accepted (`in_ready` drops after 8); outputs 16,14,…,2.
3. Forced load: after reset, `start` with `load_w`=0 → controller still accepts 72 words (`w_loaded` was 0).
4. Backpressure and bubbles: random `in_valid` gaps and `out_ready` low for 5 cycles on row 3 → row 3 value held stable, rows 4–7 not lost, results match the golden model.
5. Saturation: X=8191, W all 8191 → every output is 134217727 (positive saturation).
6. Reset mid-job: assert `rst` during LOAD_W at word 30 → next cycle IDLE with `busy`=0 and `in_ready`=0; a new `start` with `load_w`=0 loads W (72 words total).
